// File: rtl/game_controller_pkg.sv
// Shared definitions for the dino game: state encoding, screen geometry and
// the obstacle/cat overlap test, so the renderer and the sequencer agree.
package game_controller_pkg;

    typedef enum logic [1:0] {
        STATE_START_GAME = 2'b00,
        STATE_PLAY       = 2'b01,
        STATE_GAME_OVER  = 2'b10
    } game_state_t;

    localparam int SCREEN_WIDTH = 128;
    localparam int OBS_WIDTH    = 8;
    localparam int CAT_X        = 40;
    localparam int CAT_WIDTH    = 16;

    // Horizontal overlap of the obstacle with the cat; the right edge is
    // formed 9 bits wide so an obstacle near column 255 cannot wrap.
    function automatic logic obstacle_overlaps_cat(input logic [7:0] x);
        logic [8:0] left_edge;
        logic [8:0] right_edge;
        left_edge  = {1'b0, x};
        right_edge = left_edge + 9'(OBS_WIDTH);
        return (left_edge < 9'(CAT_X + CAT_WIDTH)) && (right_edge > 9'(CAT_X));
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw active-low pushbutton -> 2-flop synchronizer -> stability counter ->
// one-cycle press pulse on a debounced released->pressed transition.
// A button already held when reset is released is ignored until it has been
// seen released at least once (the press pulse is "armed" by a release).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic [CNT_W-1:0] stable_cnt_nxt;
    logic             level_r;      // 1 = debounced pressed
    logic             level_nxt;
    logic             armed_r;
    logic             armed_nxt;
    logic             press_r;
    logic             press_nxt;
    logic             pressed_s;

    assign pressed_s = ~sync_r[1];
    assign press     = press_r;

    // Two-flop synchronizer; resets to the "pressed" raw value so a stale
    // released sample cannot arm the press pulse right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button};
        end
    end

    // Count consecutive cycles that disagree with the debounced level and
    // flip the level once the count reaches DEBOUNCE_CYCLES.
    always_comb begin
        level_nxt      = level_r;
        stable_cnt_nxt = {CNT_W{1'b0}};
        armed_nxt      = armed_r | ~pressed_s;
        if (pressed_s != level_r) begin
            if (stable_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_nxt      = pressed_s;
                stable_cnt_nxt = {CNT_W{1'b0}};
            end else begin
                stable_cnt_nxt = stable_cnt_r + CNT_W'(1);
            end
        end else begin
            stable_cnt_nxt = {CNT_W{1'b0}};
        end
        press_nxt = armed_r & ~level_r & level_nxt;
    end

    // Debouncer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt_r <= {CNT_W{1'b0}};
            level_r      <= 1'b0;
            armed_r      <= 1'b0;
            press_r      <= 1'b0;
        end else begin
            stable_cnt_r <= stable_cnt_nxt;
            level_r      <= level_nxt;
            armed_r      <= armed_nxt;
            press_r      <= press_nxt;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Frame-paced sequencer for the OLED dino game: START/PLAY/GAME_OVER FSM,
// jump timer, obstacle scheduler, collision detection and score. All game
// state advances only on frame_tick; every output is a register.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int WARMUP_FRAMES   = 60,
    parameter int JUMP_FRAMES     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        button,
    output logic [1:0]  game_state,
    output logic        jump_offset,
    output logic [7:0]  obs_x,
    output logic        obs_valid,
    output logic [15:0] score,
    output logic        collision
);

    localparam int WARM_W = $clog2(WARMUP_FRAMES + 1);
    localparam int JUMP_W = $clog2(JUMP_FRAMES + 1);

    game_state_t       state_r;
    game_state_t       state_nxt;
    logic              jump_offset_r;
    logic              jump_offset_nxt;
    logic [7:0]        obs_x_r;
    logic [7:0]        obs_x_nxt;
    logic              obs_valid_r;
    logic              obs_valid_nxt;
    logic [15:0]       score_r;
    logic [15:0]       score_nxt;
    logic              collision_r;
    logic              collision_nxt;
    logic              press_pending_r;
    logic              press_pending_nxt;
    logic [WARM_W-1:0] warmup_cnt_r;
    logic [WARM_W-1:0] warmup_cnt_nxt;
    logic [JUMP_W-1:0] jump_cnt_r;
    logic [JUMP_W-1:0] jump_cnt_nxt;
    logic              press_pulse_s;
    logic              press_now_s;
    logic              hit_s;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .press (press_pulse_s)
    );

    assign game_state  = state_r;
    assign jump_offset = jump_offset_r;
    assign obs_x       = obs_x_r;
    assign obs_valid   = obs_valid_r;
    assign score       = score_r;
    assign collision   = collision_r;

    // Next-state logic: press latch, FSM, obstacle, jump timer and score.
    always_comb begin
        state_nxt         = state_r;
        jump_offset_nxt   = jump_offset_r;
        obs_x_nxt         = obs_x_r;
        obs_valid_nxt     = obs_valid_r;
        score_nxt         = score_r;
        collision_nxt     = 1'b0;
        warmup_cnt_nxt    = warmup_cnt_r;
        jump_cnt_nxt      = jump_cnt_r;
        // A pulse arriving on the tick itself is consumed by that tick.
        press_now_s       = press_pending_r | press_pulse_s;
        press_pending_nxt = press_now_s;
        hit_s             = obs_valid_r & ~jump_offset_r & obstacle_overlaps_cat(obs_x_r);

        if (frame_tick) begin
            press_pending_nxt = 1'b0;
            case (state_r)
                STATE_START_GAME: begin
                    if (press_now_s) begin
                        state_nxt       = STATE_PLAY;
                        score_nxt       = 16'h0000;
                        obs_x_nxt       = 8'(SCREEN_WIDTH);
                        warmup_cnt_nxt  = WARM_W'(WARMUP_FRAMES);
                        jump_cnt_nxt    = {JUMP_W{1'b0}};
                        jump_offset_nxt = 1'b0;
                        obs_valid_nxt   = 1'b0;
                    end else begin
                        state_nxt = STATE_START_GAME;
                    end
                end
                STATE_PLAY: begin
                    if (hit_s) begin
                        // Collision wins over a simultaneous press, which is dropped.
                        state_nxt       = STATE_GAME_OVER;
                        collision_nxt   = 1'b1;
                        jump_offset_nxt = 1'b0;
                        jump_cnt_nxt    = {JUMP_W{1'b0}};
                    end else begin
                        if (warmup_cnt_r != {WARM_W{1'b0}}) begin
                            warmup_cnt_nxt = warmup_cnt_r - WARM_W'(1);
                            obs_x_nxt      = 8'(SCREEN_WIDTH);
                            obs_valid_nxt  = 1'b0;
                        end else begin
                            obs_valid_nxt = 1'b1;
                            if (obs_x_r == 8'd0) begin
                                obs_x_nxt = 8'(SCREEN_WIDTH);
                                if (score_r == 16'hFFFF) begin
                                    score_nxt = 16'hFFFF;
                                end else begin
                                    score_nxt = score_r + 16'd1;
                                end
                            end else begin
                                obs_x_nxt = obs_x_r - 8'd1;
                            end
                        end
                        // A press while airborne is discarded, not queued.
                        if (press_now_s && (jump_cnt_r == {JUMP_W{1'b0}})) begin
                            jump_cnt_nxt    = JUMP_W'(JUMP_FRAMES);
                            jump_offset_nxt = 1'b1;
                        end else if (jump_cnt_r != {JUMP_W{1'b0}}) begin
                            jump_cnt_nxt    = jump_cnt_r - JUMP_W'(1);
                            jump_offset_nxt = (jump_cnt_r != JUMP_W'(1));
                        end else begin
                            jump_offset_nxt = 1'b0;
                        end
                    end
                end
                STATE_GAME_OVER: begin
                    // Final scene stays on screen until the player restarts.
                    if (press_now_s) begin
                        state_nxt     = STATE_START_GAME;
                        obs_valid_nxt = 1'b0;
                    end else begin
                        state_nxt = STATE_GAME_OVER;
                    end
                end
                default: begin
                    state_nxt       = STATE_START_GAME;
                    jump_offset_nxt = 1'b0;
                    jump_cnt_nxt    = {JUMP_W{1'b0}};
                    obs_valid_nxt   = 1'b0;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Game state registers; rst wins regardless of frame_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= STATE_START_GAME;
            jump_offset_r   <= 1'b0;
            obs_x_r         <= 8'(SCREEN_WIDTH);
            obs_valid_r     <= 1'b0;
            score_r         <= 16'h0000;
            collision_r     <= 1'b0;
            press_pending_r <= 1'b0;
            warmup_cnt_r    <= {WARM_W{1'b0}};
            jump_cnt_r      <= {JUMP_W{1'b0}};
        end else begin
            state_r         <= state_nxt;
            jump_offset_r   <= jump_offset_nxt;
            obs_x_r         <= obs_x_nxt;
            obs_valid_r     <= obs_valid_nxt;
            score_r         <= score_nxt;
            collision_r     <= collision_nxt;
            press_pending_r <= press_pending_nxt;
            warmup_cnt_r    <= warmup_cnt_nxt;
            jump_cnt_r      <= jump_cnt_nxt;
        end
    end

endmodule
